// File: rtl/gpr_read_port.sv
// gpr_read_port
//   General-purpose register bank (NREGS x WIDTH) with one write port and a
//   handshaked read port that returns data one cycle after acceptance.
//
// Ports:
//   clk       rising-edge system clock
//   rst       asynchronous active-low reset
//   wr_en     write strobe
//   wr_addr   write register index
//   wr_data   write data
//   rd_req    read request valid
//   rd_addr   read register index (qualified by rd_req)
//   rd_ready  port can accept a request this cycle (combinational)
//   rd_valid  read response valid (registered)
//   rd_data   read response data (registered, held while rd_valid=1)
//   rd_ack    consumer accepts the response this cycle
module gpr_read_port #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NREGS       = 8,
  parameter int unsigned AW          = 3,
  parameter int unsigned HARDWIRE_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_value;
  logic             rd_is_r0;
  logic             wr_is_r0;
  logic             wr_allowed;
  logic             accept;

  assign rd_is_r0   = (HARDWIRE_R0 != 0) && (rd_addr == '0);
  assign wr_is_r0   = (HARDWIRE_R0 != 0) && (wr_addr == '0);
  assign wr_allowed = wr_en && !wr_is_r0;

  // A new request can be taken while the current response is being consumed.
  assign rd_ready = (state == IDLE) | rd_ack;
  assign accept   = rd_req && rd_ready;

  // Value captured on acceptance: a same-edge write to the read address wins
  // over the stored value, except for a hardwired R0 which always reads zero.
  always_comb begin
    rd_value = regs[rd_addr];
    if (rd_is_r0) begin
      rd_value = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_value = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (wr_allowed) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= RESP;
            rd_valid <= 1'b1;
            rd_data  <= rd_value;
          end
        end
        RESP: begin
          if (rd_ack) begin
            if (rd_req) begin
              rd_data <= rd_value;
            end else begin
              state    <= IDLE;
              rd_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_read_port.sv
// tb_gpr_read_port
//   Drives two instances side by side (plain and hardwired-R0) with shared
//   stimulus and compares both against a register-array reference model.
module tb_gpr_read_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ack;
  logic        rd_ready [2];
  logic        rd_valid [2];
  logic [15:0] rd_data  [2];

  int checks = 0;
  int errors = 0;

  // Reference model: storage per instance, plus the outstanding response.
  logic [15:0] mem      [2][8];
  logic        exp_valid;
  logic [15:0] exp_data [2];

  always #5 clk = ~clk;

  gpr_read_port #(.WIDTH(16), .NREGS(8), .AW(3), .HARDWIRE_R0(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready[0]),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_ack(rd_ack)
  );

  gpr_read_port #(.WIDTH(16), .NREGS(8), .AW(3), .HARDWIRE_R0(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready[1]),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_ack(rd_ack)
  );

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) mem[k][r] = 16'h0000;
      exp_data[k] = 16'h0000;
    end
    exp_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_req = 0; rd_addr = 0; rd_ack = 0;
  endtask

  // One clock edge: model update from the inputs present at the edge, then
  // outputs are ready to sample 1ns after the edge.
  task automatic tick();
    logic        taken;
    logic        next_valid;
    logic [15:0] value [2];
    taken      = rst && rd_req && (!exp_valid || rd_ack);
    next_valid = exp_valid;
    if (taken) next_valid = 1'b1;
    else if (exp_valid && rd_ack) next_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1 && rd_addr == 0) value[k] = 16'h0000;
      else if (wr_en && wr_addr == rd_addr) value[k] = wr_data;
      else value[k] = mem[k][rd_addr];
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (taken) exp_data[k] = value[k];
        if (wr_en && !(k == 1 && wr_addr == 0)) mem[k][wr_addr] = wr_data;
      end
      exp_valid = next_valid;
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    idle_inputs();
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_valid[k] !== 1'b0 || rd_data[k] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold dut%0d valid=%b data=%h required valid=0 data=0000", k, rd_valid[k], rd_data[k]);
      end
    end
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_valid[k] !== 1'b0 || rd_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle dut%0d valid=%b ready=%b required valid=0 ready=1", k, rd_valid[k], rd_ready[k]);
      end
    end
    rd_req = 1; rd_addr = 5;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_valid[k] !== 1'b1 || rd_data[k] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read_r5 dut%0d valid=%b data=%h required valid=1 data=0000", k, rd_valid[k], rd_data[k]);
      end
    end
    rd_req = 0; rd_ack = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_write_read();
    write_reg(3, 16'h3333);
    rd_req = 1; rd_addr = 3; rd_ack = 1;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'h3333) begin
      errors++;
      $display("FAIL write_read valid=%b data=%h required valid=1 data=3333", rd_valid[0], rd_data[0]);
    end
    rd_req = 0;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_read_release valid=%b required 0", rd_valid[0]);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    write_reg(2, 16'h1234);
    wr_en = 1; wr_addr = 2; wr_data = 16'h333F;
    rd_req = 1; rd_addr = 2; rd_ack = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_data[k] !== 16'h333F) begin
        errors++;
        $display("FAIL bypass dut%0d data=%h required 333F", k, rd_data[k]);
      end
    end
    idle_inputs();
    rd_ack = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_stall_snapshot();
    write_reg(4, 16'h1111);
    rd_req = 1; rd_addr = 4; rd_ack = 0;
    tick();
    for (int c = 0; c < 3; c++) begin
      wr_en = 1; wr_addr = 4; wr_data = 16'hBEEF;
      rd_req = 1; rd_addr = 4; rd_ack = 0;
      #1;
      checks++;
      if (rd_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cycle%0d ready=%b required 0", c, rd_ready[0]);
      end
      tick();
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'h1111) begin
        errors++;
        $display("FAIL stall_snapshot cycle%0d valid=%b data=%h required valid=1 data=1111", c, rd_valid[0], rd_data[0]);
      end
    end
    wr_en = 0; rd_req = 1; rd_addr = 4; rd_ack = 1;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL stall_reread valid=%b data=%h required valid=1 data=BEEF", rd_valid[0], rd_data[0]);
    end
    rd_req = 0;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) write_reg(3'(n), 16'(n * 16'h0101));
    rd_req = 1; rd_ack = 1;
    for (int n = 0; n < 8; n++) begin
      rd_addr = 3'(n);
      tick();
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'(n * 16'h0101)) begin
        errors++;
        $display("FAIL back_to_back addr%0d valid=%b data=%h required valid=1 data=%h", n, rd_valid[0], rd_data[0], 16'(n * 16'h0101));
      end
      checks++;
      if (rd_data[1] !== exp_data[1]) begin
        errors++;
        $display("FAIL back_to_back_hw addr%0d data=%h required %h", n, rd_data[1], exp_data[1]);
      end
    end
    rd_req = 0;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    rd_req = 1; rd_addr = 7; rd_ack = 0;
    tick();
    checks++;
    if (rd_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre valid=%b required 1", rd_valid[0]);
    end
    #2;
    rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_async dut%0d valid=%b required 0", k, rd_valid[k]);
      end
    end
    idle_inputs();
    tick();
    rst = 1;
    rd_req = 1; rd_ack = 1;
    for (int n = 0; n < 8; n++) begin
      rd_addr = 3'(n);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd_valid[k] !== 1'b1 || rd_data[k] !== 16'h0000) begin
          errors++;
          $display("FAIL reset_mid_clear dut%0d addr%0d valid=%b data=%h required valid=1 data=0000", k, n, rd_valid[k], rd_data[k]);
        end
      end
    end
    rd_req = 0;
    tick();
    idle_inputs();
  endtask

  task automatic test_hardwire_r0();
    write_reg(0, 16'hFFFF);
    rd_req = 1; rd_addr = 0; rd_ack = 1;
    tick();
    checks++;
    if (rd_data[0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL r0_plain data=%h required FFFF", rd_data[0]);
    end
    checks++;
    if (rd_data[1] !== 16'h0000) begin
      errors++;
      $display("FAIL r0_hardwired data=%h required 0000", rd_data[1]);
    end
    wr_en = 1; wr_addr = 0; wr_data = 16'hAAAA;
    tick();
    checks++;
    if (rd_data[0] !== 16'hAAAA || rd_data[1] !== 16'h0000) begin
      errors++;
      $display("FAIL r0_bypass data0=%h data1=%h required AAAA 0000", rd_data[0], rd_data[1]);
    end
    idle_inputs();
    rd_ack = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom);
      rd_req  = ($urandom_range(0, 3) != 0);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      rd_ack  = ($urandom_range(0, 2) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd_ready[k] !== (!exp_valid || rd_ack)) begin
          errors++;
          $display("FAIL random_ready dut%0d cycle%0d ready=%b required %b", k, c, rd_ready[k], !exp_valid || rd_ack);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd_valid[k] !== exp_valid || (exp_valid && rd_data[k] !== exp_data[k])) begin
          errors++;
          $display("FAIL random_resp dut%0d cycle%0d valid=%b data=%h required valid=%b data=%h", k, c, rd_valid[k], rd_data[k], exp_valid, exp_data[k]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_clear();
    test_reset();
    test_write_read();
    test_bypass();
    test_stall_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_hardwire_r0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
